// File: rtl/hidden_layer_mac.sv
// hidden_layer_mac
//   Computes one output-neuron value from the hidden-unit RAM. On start it
//   steps through all 2**ADDR_WIDTH entries of the hidden RAM and the weight
//   RAM together and accumulates the signed products hidden[i]*weight[i].
//   It then emits the result, saturated to DATA_WIDTH and optionally ReLU'd,
//   together with a one-cycle done pulse.
//   Both RAMs register their read address, so read data lags rd_addr by one
//   cycle.
// Ports
//   clk, rst_n : clock and asynchronous active-low reset
//   start      : request a dot product; only looked at in IDLE
//   rd_addr    : read address shared by the hidden RAM and the weight RAM
//   hid_q/wt_q : RAM read data, valid one cycle after rd_addr
//   busy       : high from the accepting edge until the done cycle
//   done       : one-cycle pulse; result and acc are valid from this cycle
//   result     : saturated (and ReLU'd if RELU) value; held until next done
//   acc        : raw accumulator; held after done, cleared on accept
module hidden_layer_mac #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5,
  parameter int ACC_WIDTH  = 24,
  parameter int FRAC_BITS  = 0,
  parameter int RELU       = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  output logic [ADDR_WIDTH-1:0]        rd_addr,
  input  logic signed [DATA_WIDTH-1:0] hid_q,
  input  logic signed [DATA_WIDTH-1:0] wt_q,
  output logic                         busy,
  output logic                         done,
  output logic signed [DATA_WIDTH-1:0] result,
  output logic signed [ACC_WIDTH-1:0]  acc
);
  localparam int PW = 2*DATA_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST = {ADDR_WIDTH{1'b1}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'((2**(DATA_WIDTH-1))-1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FINISH} state_t;
  state_t state;

  // vld_pipe[0]: an address is on rd_addr this cycle.
  // vld_pipe[1]: the RAM data for that address is on hid_q/wt_q this cycle.
  logic [1:0] vld_pipe;

  logic signed [PW-1:0]         prod;
  logic signed [ACC_WIDTH-1:0]  prod_ext;
  logic signed [ACC_WIDTH-1:0]  shifted;
  logic signed [DATA_WIDTH-1:0] sat_val;

  assign prod     = hid_q * wt_q;
  assign prod_ext = {{(ACC_WIDTH-PW){prod[PW-1]}}, prod};
  assign shifted  = acc >>> FRAC_BITS;

  always_comb begin
    sat_val = shifted[DATA_WIDTH-1:0];
    if (shifted > SAT_MAX)      sat_val = SAT_MAX[DATA_WIDTH-1:0];
    else if (shifted < SAT_MIN) sat_val = SAT_MIN[DATA_WIDTH-1:0];
    // The sign of the saturated value matches the sign of s, so testing
    // its MSB is enough for the ReLU.
    if (RELU != 0 && sat_val[DATA_WIDTH-1]) sat_val = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rd_addr  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      acc      <= '0;
      vld_pipe <= '0;
    end else begin
      done        <= 1'b0;
      vld_pipe[1] <= vld_pipe[0];
      if (vld_pipe[1]) acc <= acc + prod_ext;
      case (state)
        IDLE: if (start) begin
          state       <= RUN;
          acc         <= '0;
          rd_addr     <= '0;
          busy        <= 1'b1;
          vld_pipe[0] <= 1'b1;
        end
        RUN: begin
          if (rd_addr == LAST) begin
            state       <= DRAIN;
            vld_pipe[0] <= 1'b0;
          end else begin
            rd_addr <= rd_addr + 1'b1;
          end
        end
        // The last product is added on the same edge that leaves DRAIN.
        DRAIN: state <= FINISH;
        FINISH: begin
          state   <= IDLE;
          result  <= sat_val;
          done    <= 1'b1;
          busy    <= 1'b0;
          rd_addr <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_hidden_layer_mac.sv
module tb_hidden_layer_mac;
  localparam int N = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;

  logic [4:0]         rd_addr_a, rd_addr_b;
  logic signed [7:0]  hid_q_a = '0, wt_q_a = '0, hid_q_b = '0, wt_q_b = '0;
  logic               busy_a, busy_b, done_a, done_b;
  logic signed [7:0]  res_a, res_b;
  logic signed [23:0] acc_a, acc_b;

  logic signed [7:0] hid_mem [N];
  logic signed [7:0] wt_mem  [N];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hidden_layer_mac #(.RELU(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .rd_addr(rd_addr_a),
    .hid_q(hid_q_a), .wt_q(wt_q_a), .busy(busy_a), .done(done_a),
    .result(res_a), .acc(acc_a));

  hidden_layer_mac #(.RELU(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .rd_addr(rd_addr_b),
    .hid_q(hid_q_b), .wt_q(wt_q_b), .busy(busy_b), .done(done_b),
    .result(res_b), .acc(acc_b));

  // RAM models with a registered read address
  always @(posedge clk) begin
    hid_q_a <= hid_mem[rd_addr_a];
    wt_q_a  <= wt_mem[rd_addr_a];
    hid_q_b <= hid_mem[rd_addr_b];
    wt_q_b  <= wt_mem[rd_addr_b];
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference model: plain dot product, then clamp and ReLU
  function automatic longint model_acc();
    longint s = 0;
    for (int i = 0; i < N; i++) s += longint'(hid_mem[i]) * longint'(wt_mem[i]);
    return s;
  endfunction

  function automatic longint model_res(input longint a, input bit relu);
    longint s = a;
    if (s > 127) s = 127;
    else if (s < -128) s = -128;
    if (relu && s < 0) s = 0;
    return s;
  endfunction

  task automatic fill(input int pat);
    for (int i = 0; i < N; i++) begin
      case (pat)
        0: begin hid_mem[i] = 8'sd1;   wt_mem[i] = 8'sd1;   end
        1: begin hid_mem[i] = 8'sd127; wt_mem[i] = 8'sd127; end
        2: begin hid_mem[i] = 8'sd127; wt_mem[i] = -8'sd128; end
        3: begin hid_mem[i] = 8'(i);   wt_mem[i] = (i % 2 == 1) ? -8'sd1 : 8'sd1; end
        4: begin hid_mem[i] = 8'($urandom); wt_mem[i] = 8'($urandom); end
        default: begin
          hid_mem[i] = 8'($urandom_range(0, 15)) - 8'sd8;
          wt_mem[i]  = 8'($urandom_range(0, 7)) - 8'sd4;
        end
      endcase
    end
  endtask

  // Runs one op from a start pulse. glitch: extra start pulses mid-op.
  // chain: start held high into the done cycle, so a second op must follow.
  task automatic run_op(input string nm, input longint ea, input longint er,
                        input longint err, input bit glitch, input bit chain);
    int n;
    bit seen, addr_ok, busy_ok;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;   // accepting edge E0
    addr_ok = (rd_addr_a == 5'd0);
    busy_ok = busy_a;
    n = 0; seen = 1'b0;
    while (n < 60 && !seen) begin
      start = (glitch && (n == 4 || n == 19)) || (chain && n >= 30);
      @(posedge clk); #1; n++;
      if (done_a) seen = 1'b1;
      else begin
        if (!busy_a) busy_ok = 1'b0;
        if (rd_addr_a != ((n <= 31) ? 5'(n) : 5'd31)) addr_ok = 1'b0;
      end
    end
    chk({nm, " latency"}, n, 34);
    chk({nm, " done_relu"}, done_b, 1);
    chk({nm, " rd_addr_seq"}, addr_ok, 1);
    chk({nm, " busy_during"}, busy_ok, 1);
    chk({nm, " busy_at_done"}, busy_a, 0);
    chk({nm, " rd_addr_at_done"}, rd_addr_a, 0);
    chk({nm, " acc"}, longint'(acc_a), ea);
    chk({nm, " result"}, longint'(res_a), er);
    chk({nm, " acc_relu"}, longint'(acc_b), ea);
    chk({nm, " result_relu"}, longint'(res_b), err);
    @(posedge clk); #1 start = 1'b0;
    chk({nm, " done_width"}, done_a, 0);
    if (chain) begin
      chk({nm, " restart_busy"}, busy_a, 1);
      n = 1; seen = 1'b0;
      while (n < 60 && !seen) begin
        @(posedge clk); #1; n++;
        if (done_a) seen = 1'b1;
      end
      chk({nm, " latency2"}, n, 35);
      chk({nm, " acc2"}, longint'(acc_a), ea);
      chk({nm, " result2"}, longint'(res_a), er);
    end
    if (glitch || chain) begin
      seen = 1'b0;
      for (int k = 0; k < 40; k++) begin
        @(posedge clk); #1;
        if (done_a || busy_a) seen = 1'b1;
      end
      chk({nm, " no_extra_op"}, seen, 0);
    end
  endtask

  typedef struct {
    string  nm;
    int     pat;
    bit     use_model;
    longint exp_acc;
    longint exp_res;
    longint exp_relu;
  } vec_t;

  initial begin
    vec_t vecs [7];
    longint ea, er, err;
    bit seen;

    vecs[0] = '{"ones",     0, 1'b0, 32,      32,   32};
    vecs[1] = '{"pos_sat",  1, 1'b0, 516128,  127,  127};
    vecs[2] = '{"neg_sat",  2, 1'b0, -520192, -128, 0};
    vecs[3] = '{"alt_sign", 3, 1'b0, -16,     -16,  0};
    vecs[4] = '{"rand_a",   4, 1'b1, 0, 0, 0};
    vecs[5] = '{"rand_b",   5, 1'b1, 0, 0, 0};
    vecs[6] = '{"rand_c",   4, 1'b1, 0, 0, 0};

    fill(0);
    repeat (3) @(posedge clk);
    #1;
    chk("reset rd_addr", rd_addr_a, 0);
    chk("reset busy", busy_a, 0);
    chk("reset done", done_a, 0);
    chk("reset result", res_a, 0);
    chk("reset acc", acc_a, 0);
    rst_n = 1'b1;

    for (int t = 0; t < 7; t++) begin
      fill(vecs[t].pat);
      if (vecs[t].use_model) begin
        ea = model_acc(); er = model_res(ea, 1'b0); err = model_res(ea, 1'b1);
      end else begin
        ea = vecs[t].exp_acc; er = vecs[t].exp_res; err = vecs[t].exp_relu;
      end
      run_op(vecs[t].nm, ea, er, err, 1'b0, 1'b0);
    end

    // start while busy is ignored; start held through done chains a second op
    fill(1);
    run_op("glitch", 516128, 127, 127, 1'b1, 1'b0);
    fill(3);
    run_op("chain", -16, -16, 0, 1'b0, 1'b1);

    // Reset in the middle of an op
    fill(1);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (15) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midreset rd_addr", rd_addr_a, 0);
    chk("midreset busy", busy_a, 0);
    chk("midreset done", done_a, 0);
    chk("midreset result", res_a, 0);
    chk("midreset acc", acc_a, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (done_a || busy_a) seen = 1'b1;
    end
    chk("midreset no_done", seen, 0);
    fill(2);
    run_op("after_reset", -520192, -128, 0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
